// File: rtl/typewriter_char_pacer_pkg.sv
// typewriter_char_pacer_pkg: shared pacer FSM state encodings and default strobe spacing
package typewriter_char_pacer_pkg;
  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_GAP} pacer_state_t;
  localparam int GAP_CYCLES_DEFAULT = 1000000;
endpackage

// File: rtl/typewriter_char_pacer_if.sv
// typewriter_char_pacer_if: character handshake in, paced strobe out
//  in_char/in_valid/in_ready: upstream enqueue handshake
//  char_out/char_strobe: one-cycle strobe with held code toward the typewriter renderer
interface typewriter_char_pacer_if #(parameter int CHAR_W = 7);
  logic [CHAR_W-1:0] in_char;
  logic in_valid;
  logic in_ready;
  logic [CHAR_W-1:0] char_out;
  logic char_strobe;
  modport master(output in_char, in_valid, input in_ready, char_out, char_strobe);
  modport slave(input in_char, in_valid, output in_ready, char_out, char_strobe);
endinterface

// File: rtl/typewriter_char_pacer_fifo.sv
// typewriter_char_pacer_fifo: sync FIFO, level from pointer difference, no read-through
//  clk, reset: clock and sync active-high reset
//  clear: sync empty; push/wdata: write (ignored when full); pop: advance head (ignored when empty)
//  rdata: head entry; level/full/empty: occupancy derived from registered pointers
module typewriter_char_pacer_fifo #(
  parameter int W = 7,
  parameter int DEPTH = 16,
  parameter int LW = $clog2(DEPTH) + 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic push,
  input  logic [W-1:0] wdata,
  input  logic pop,
  output logic [W-1:0] rdata,
  output logic [LW-1:0] level,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_push = push & ~full & ~clear;
  assign do_pop = pop & ~empty & ~clear;
  // the extra pointer MSB makes wr_ptr - rd_ptr distinguish full from empty
  assign level = wr_ptr - rd_ptr;
  assign full = level == LW'(DEPTH);
  assign empty = level == '0;
  assign rdata = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/typewriter_char_pacer.sv
// typewriter_char_pacer: buffers characters and strobes them out no closer than GAP_CYCLES apart
//  clk, reset: pixel clock and sync active-high reset
//  flush: sync clear of FIFO, gap timer and overflow (char_out kept)
//  bus: slave side of the enqueue handshake and paced strobe output
//  level: FIFO occupancy; overflow: sticky, set by in_valid while not ready
module typewriter_char_pacer
  import typewriter_char_pacer_pkg::*;
#(
  parameter int CHAR_W = 7,
  parameter int DEPTH = 16,
  parameter int GAP_CYCLES = GAP_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  typewriter_char_pacer_if.slave bus,
  output logic [$clog2(DEPTH):0] level,
  output logic overflow
);
  localparam int GW = $clog2(GAP_CYCLES);
  pacer_state_t state, state_n;
  logic [GW-1:0] gap;
  logic [CHAR_W-1:0] head;
  logic full, empty, push;
  // NUL is accepted but never stored
  assign push = bus.in_valid & (bus.in_char != '0);
  assign bus.in_ready = ~full;
  typewriter_char_pacer_fifo #(.W(CHAR_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .clear(flush),
    .push(push),
    .wdata(bus.in_char),
    .pop(state == S_EMIT),
    .rdata(head),
    .level(level),
    .full(full),
    .empty(empty)
  );
  // a gap that expires with data waiting goes straight to EMIT so back-to-back strobes land exactly GAP_CYCLES apart
  always_comb begin
    state_n = state;
    state_n = (state == S_IDLE) ? (empty ? S_IDLE : S_EMIT) :
              (state == S_EMIT) ? S_GAP :
              (gap != '0)       ? S_GAP :
              (empty ? S_IDLE : S_EMIT);
  end
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state <= S_IDLE;
      gap <= '0;
      char_strobe_clear();
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      gap <= (state == S_EMIT) ? GW'(GAP_CYCLES - 2) : (state == S_GAP && gap != '0) ? gap - 1'b1 : gap;
      bus.char_strobe <= state == S_EMIT;
      if (bus.in_valid && full) overflow <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) bus.char_out <= '0;
    else if (!flush && state == S_EMIT) bus.char_out <= head;
  end
  function automatic void char_strobe_clear();
    bus.char_strobe <= 1'b0;
  endfunction
endmodule

// File: tb/tb_typewriter_char_pacer.sv
// tb_typewriter_char_pacer: randomized scoreboard bench against a timing-rule reference model
module tb_typewriter_char_pacer;
  localparam int DEPTH = 4;
  localparam int GAP = 4;
  logic clk = 0;
  logic reset = 1;
  logic flush = 0;
  logic [2:0] level;
  logic overflow;
  typewriter_char_pacer_if #(.CHAR_W(7)) bus();
  typewriter_char_pacer #(.CHAR_W(7), .DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .bus(bus),
    .level(level),
    .overflow(overflow)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [6:0] c;
    int t;
    int s;
  } ent_t;
  ent_t q[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int last_s = -1000;
  int last_char = 0;
  bit ovf_exp = 0;
  bit clr_pend = 0;
  bit rst_pend = 0;
  bit ovf_pend = 0;
  bit run = 0;
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask
  // a character written at cycle t is resident while t < c < s, where s is its strobe cycle
  function automatic int lvl_at(input int c);
    int n = 0;
    foreach (q[i]) if (q[i].t < c && q[i].s > c) n++;
    return n;
  endfunction
  task automatic step(input logic v, input logic [6:0] ch, input logic fl, input logic rs);
    bit rdy;
    int s;
    @(posedge clk);
    #1;
    rdy = lvl_at(cyc) != DEPTH;
    chk("in_ready", int'(bus.in_ready), int'(rdy));
    bus.in_valid = v;
    bus.in_char = ch;
    flush = fl;
    reset = rs;
    if (rs || fl) begin
      clr_pend = 1;
      rst_pend = rs;
    end else if (v) begin
      if (!rdy) ovf_pend = 1;
      else if (ch != 0) begin
        s = (cyc + 3 > last_s + GAP) ? cyc + 3 : last_s + GAP;
        q.push_back('{ch, cyc, s});
        last_s = s;
      end
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask
  always @(negedge clk) begin
    if (run) begin
      bit exp_s;
      chk("level", int'(level), lvl_at(cyc));
      exp_s = q.size() > 0 && q[0].s == cyc;
      chk("char_strobe", int'(bus.char_strobe), int'(exp_s));
      if (exp_s) begin
        chk("char_code", int'(bus.char_out), int'(q[0].c));
        last_char = int'(q[0].c);
        void'(q.pop_front());
      end else chk("char_out_hold", int'(bus.char_out), last_char);
      chk("overflow", int'(overflow), int'(ovf_exp));
      if (clr_pend) begin
        q.delete();
        last_s = -1000;
        ovf_exp = 0;
        if (rst_pend) last_char = 0;
      end else if (ovf_pend) ovf_exp = 1;
      clr_pend = 0;
      rst_pend = 0;
      ovf_pend = 0;
    end
  end
  initial begin
    bus.in_valid = 0;
    bus.in_char = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    run = 1;
    step(1, 7'h41, 0, 0);
    idle(12);
    step(1, 7'h41, 0, 0);
    step(1, 7'h42, 0, 0);
    step(1, 7'h43, 0, 0);
    idle(20);
    for (int i = 0; i < 7; i++) step(1, 7'(7'h61 + i), 0, 0);
    idle(40);
    step(0, 0, 1, 0);
    step(1, 7'h58, 0, 0);
    step(1, 7'h00, 0, 0);
    step(1, 7'h59, 0, 0);
    idle(15);
    step(1, 7'h31, 0, 0);
    step(1, 7'h32, 0, 0);
    step(1, 7'h33, 0, 0);
    idle(1);
    step(0, 0, 1, 0);
    idle(2);
    step(1, 7'h5a, 0, 0);
    idle(12);
    step(1, 7'h34, 0, 0);
    step(1, 7'h35, 0, 0);
    step(1, 7'h36, 0, 0);
    idle(1);
    step(0, 0, 0, 1);
    idle(10);
    for (int i = 0; i < 2000; i++)
      step(1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) == 0) ? 7'h00 : 7'($urandom_range(1, 127)),
           1'($urandom_range(0, 59) == 0),
           1'($urandom_range(0, 149) == 0));
    idle(40);
    chk("drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
